sw_loop_monitor: RTL

//  Downstream checker for the one-hot software-loop model (locations L0..L6, data register X).

---
 rtl/sw_loop_pkg.sv | 30 +++
 rtl/sw_loop_monitor_if.sv | 12 +
 rtl/sw_loop_edge_chk.sv | 64 ++++++
 rtl/sw_loop_monitor.sv | 107 ++++++++++
 4 files changed

// File: rtl/sw_loop_pkg.sv
// Shared constants for the one-hot software loop and its monitor.
// Location indices, monitor state encoding and default loop constants.
package sw_loop_pkg;

  localparam int NLOC = 7;

  localparam int L0 = 0;
  localparam int L1 = 1;
  localparam int L2 = 2;
  localparam int L3 = 3;
  localparam int L4 = 4;
  localparam int L5 = 5;
  localparam int L6 = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    EXIT = 3'd2,
    FAIL = 3'd3,
    VIOL = 3'd4
  } mon_state_t;

  localparam int K_W     = 6;
  localparam int K_INIT  = 1;
  localparam int K_INC   = 3;
  localparam int K_COND  = 17;
  localparam int K_PROP  = 19;
  localparam int K_CW    = 4;

endpackage

// File: rtl/sw_loop_monitor_if.sv
// Sample bus from the loop model to its monitor.
// Carries loc_vld, the location vector loc and data register x.
interface sw_loop_monitor_if #(
  parameter int W = 6
) ();
  logic         loc_vld;
  logic [6:0]   loc;
  logic [W-1:0] x;

  modport master (output loc_vld, output loc, output x);
  modport slave  (input  loc_vld, input  loc, input  x);
endinterface

// File: rtl/sw_loop_edge_chk.sv
// Combinational CFG edge checker for one (prev, cur) sample pair.
// Ports: i_prev_loc/i_prev_x, i_loc/i_x in; o_onehot_ok, o_edge_ok, o_next_is_l5/l6, o_is_loopback out.
module sw_loop_edge_chk
  import sw_loop_pkg::*;
#(
  parameter int W     = K_W,
  parameter int KINC  = K_INC,
  parameter int KCOND = K_COND,
  parameter int KPROP = K_PROP
) (
  input  logic [6:0]   i_prev_loc,
  input  logic [W-1:0] i_prev_x,
  input  logic [6:0]   i_loc,
  input  logic [W-1:0] i_x,
  output logic         o_onehot_ok,
  output logic         o_edge_ok,
  output logic         o_next_is_l5,
  output logic         o_next_is_l6,
  output logic         o_is_loopback
);

  logic [W-1:0] w_inc_x;
  logic         w_same_x;
  logic         w_inc_ok;
  logic         w_lt_prop;
  logic         w_lt_cond;
  logic         w_stutter;
  logic         w_cfg_ok;

  assign w_inc_x   = i_prev_x + W'(KINC);
  assign w_same_x  = (i_x == i_prev_x);
  assign w_inc_ok  = (i_x == w_inc_x);
  assign w_lt_prop = (i_prev_x < W'(KPROP));
  assign w_lt_cond = (i_prev_x < W'(KCOND));

  // Holding still is fine anywhere before the terminal locations.
  assign w_stutter = (i_loc == i_prev_loc) && w_same_x
                   && (|i_prev_loc[L4:L0]);

  always_comb begin
    w_cfg_ok = 1'b0;
    case (1'b1)
      i_prev_loc[L0]: w_cfg_ok = i_loc[L1] & w_same_x;
      i_prev_loc[L1]: w_cfg_ok = (i_loc[L2] & w_lt_prop & w_inc_ok)
                               | (i_loc[L6] & ~w_lt_prop & w_same_x);
      i_prev_loc[L2]: w_cfg_ok = i_loc[L3] & w_same_x;
      i_prev_loc[L3]: w_cfg_ok = ((i_loc[L1] & w_lt_cond)
                               | (i_loc[L4] & ~w_lt_cond)) & w_same_x;
      i_prev_loc[L4]: w_cfg_ok = ((i_loc[L5] & w_lt_prop)
                               | (i_loc[L6] & ~w_lt_prop)) & w_same_x;
      i_prev_loc[L5]: w_cfg_ok = i_loc[L5] & w_same_x;
      i_prev_loc[L6]: w_cfg_ok = i_loc[L6] & w_same_x;
      default:        w_cfg_ok = 1'b0;
    endcase
  end

  assign o_onehot_ok   = $onehot(i_loc);
  assign o_edge_ok     = w_cfg_ok | w_stutter;
  assign o_next_is_l5  = i_loc[L5];
  assign o_next_is_l6  = i_loc[L6];
  assign o_is_loopback = i_prev_loc[L3] & i_loc[L1]
                       & w_lt_cond & w_same_x;

endmodule

// File: rtl/sw_loop_monitor.sv
// Replays the loop CFG on each valid sample; flags violations, counts iterations.
// Ports: clk, rst, smp (loc_vld/loc/x); state, iter_cnt, viol, err_hit, done, prop out.
module sw_loop_monitor
  import sw_loop_pkg::*;
#(
  parameter int W     = K_W,
  parameter int KINIT = K_INIT,
  parameter int KINC  = K_INC,
  parameter int KCOND = K_COND,
  parameter int KPROP = K_PROP,
  parameter int CW    = K_CW
) (
  input  logic                clk,
  input  logic                rst,
  sw_loop_monitor_if.slave    smp,
  output logic [2:0]          state,
  output logic [CW-1:0]       iter_cnt,
  output logic                viol,
  output logic                err_hit,
  output logic                done,
  output logic                prop
);

  mon_state_t   r_state;
  mon_state_t   w_nxt;
  logic [6:0]   r_prev_loc;
  logic [W-1:0] r_prev_x;
  logic [CW-1:0] r_iter;
  logic         r_viol;
  logic         r_err;

  logic w_onehot;
  logic w_edge;
  logic w_l5;
  logic w_l6;
  logic w_loop;
  logic w_ok;
  logic w_first_ok;
  logic w_cnt_inc;

  sw_loop_edge_chk #(
    .W     (W),
    .KINC  (KINC),
    .KCOND (KCOND),
    .KPROP (KPROP)
  ) u_edge (
    .i_prev_loc    (r_prev_loc),
    .i_prev_x      (r_prev_x),
    .i_loc         (smp.loc),
    .i_x           (smp.x),
    .o_onehot_ok   (w_onehot),
    .o_edge_ok     (w_edge),
    .o_next_is_l5  (w_l5),
    .o_next_is_l6  (w_l6),
    .o_is_loopback (w_loop)
  );

  assign w_ok       = w_onehot & w_edge;
  assign w_first_ok = (smp.loc == 7'b0000001)
                    && (smp.x == W'(KINIT));

  always_comb begin
    w_nxt     = r_state;
    w_cnt_inc = 1'b0;
    case (r_state)
      IDLE: w_nxt = w_first_ok ? RUN : VIOL;
      RUN: begin
        if (!w_ok)     w_nxt = VIOL;
        else if (w_l5) w_nxt = EXIT;
        else if (w_l6) w_nxt = FAIL;
        else           w_nxt = RUN;
        w_cnt_inc = w_ok & w_loop;
      end
      // Terminal samples must repeat the last one exactly.
      EXIT, FAIL: w_nxt = w_ok ? r_state : VIOL;
      default:    w_nxt = VIOL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prev_loc <= '0;
      r_prev_x   <= '0;
      r_iter     <= '0;
      r_viol     <= 1'b0;
      r_err      <= 1'b0;
    end else if (smp.loc_vld) begin
      r_state    <= w_nxt;
      r_prev_loc <= smp.loc;
      r_prev_x   <= smp.x;
      if (w_cnt_inc && (r_iter != {CW{1'b1}}))
        r_iter <= r_iter + 1'b1;
      if (w_nxt == VIOL) r_viol <= 1'b1;
      if (w_nxt == FAIL) r_err  <= 1'b1;
    end
  end

  assign state    = r_state;
  assign iter_cnt = r_iter;
  assign viol     = r_viol;
  assign err_hit  = r_err;
  assign done     = (r_state == EXIT) || (r_state == FAIL)
                 || (r_state == VIOL);
  assign prop     = !r_err && !r_viol;

endmodule
